// File: rtl/rr_stream_mux.sv
// rr_stream_mux
//   Registered N-channel stream multiplexer with valid/ready handshaking.
//   Arbitration is either a fixed channel select or a fair round-robin that
//   starts its search one past the last granted channel. The output is a
//   single register slot that refills in the same cycle it drains, giving
//   one beat per cycle. A free-running counter tallies delivered beats.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   inp_data   packed channel data, channel k at [k*DATA_W +: DATA_W]
//   inp_valid  per-channel valid
//   inp_ready  per-channel ready (combinational, one-hot or zero)
//   mode_rr    0 = fixed select, 1 = round-robin
//   selec      channel index used in fixed mode
//   out_y      registered output data
//   out_ch     channel index of the beat held in out_y
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
//   beat_cnt   number of beats accepted downstream (wrapping)
`timescale 1ns/1ps
module rr_stream_mux #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] inp_data,
    input  logic [NUM_CH-1:0]        inp_valid,
    output logic [NUM_CH-1:0]        inp_ready,
    input  logic                     mode_rr,
    input  logic [SEL_W-1:0]         selec,
    output logic [DATA_W-1:0]        out_y,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CNT_W-1:0]         beat_cnt
);

    logic [SEL_W-1:0]  r_rr_ptr;
    logic [DATA_W-1:0] r_out_y;
    logic [SEL_W-1:0]  r_out_ch;
    logic              r_out_valid;
    logic [CNT_W-1:0]  r_beat_cnt;

    logic [SEL_W-1:0]  w_grant;
    logic              w_grant_vld;
    logic              w_load_en;
    logic              w_accept;
    logic [DATA_W-1:0] w_data;
    logic [SEL_W-1:0]  w_idx;
    int                w_sum;

    // Arbitration. In round-robin the candidates are scanned from farthest
    // to nearest (relative to r_rr_ptr) so the nearest valid channel is the
    // last one written and therefore wins, without needing an early exit.
    always_comb begin
        w_grant     = '0;
        w_grant_vld = 1'b0;
        w_sum       = 0;
        w_idx       = '0;
        if (!mode_rr) begin
            if (int'(selec) < NUM_CH) begin
                w_grant     = selec;
                w_grant_vld = inp_valid[selec];
            end
        end else begin
            for (int i = NUM_CH; i >= 1; i--) begin
                w_sum = int'(r_rr_ptr) + i;
                if (w_sum >= NUM_CH) begin
                    w_sum = w_sum - NUM_CH;
                end
                w_idx = SEL_W'(w_sum);
                if (inp_valid[w_idx]) begin
                    w_grant     = w_idx;
                    w_grant_vld = 1'b1;
                end
            end
        end
    end

    // The slot can take a new beat when empty or when it drains this cycle.
    // Gating with rst_n keeps every ready low while reset is asserted.
    assign w_accept  = r_out_valid && out_ready;
    assign w_load_en = rst_n && (!r_out_valid || out_ready) && w_grant_vld;

    always_comb begin
        w_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_data = inp_data[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        inp_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            inp_ready[k] = w_load_en && (w_grant == SEL_W'(k));
        end
    end

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_y     <= '0;
            r_out_ch    <= '0;
            r_out_valid <= 1'b0;
            r_beat_cnt  <= '0;
            r_rr_ptr    <= SEL_W'(NUM_CH - 1);
        end else begin
            if (w_load_en) begin
                r_out_y     <= w_data;
                r_out_ch    <= w_grant;
                r_out_valid <= 1'b1;
                // The pointer only advances on round-robin grants, so a
                // fixed-mode interlude leaves the fairness history intact.
                if (mode_rr) begin
                    r_rr_ptr <= w_grant;
                end
            end else if (w_accept) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            end
        end
    end

    assign out_y     = r_out_y;
    assign out_ch    = r_out_ch;
    assign out_valid = r_out_valid;
    assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_rr_stream_mux.sv
`timescale 1ns/1ps
module tb_rr_stream_mux;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int SW  = 2;
    localparam int CW  = 16;
    localparam int NB  = 3;
    localparam int CWB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [N*DW-1:0] a_data;
    logic [N-1:0]    a_valid, a_ready;
    logic            a_mode;
    logic [SW-1:0]   a_sel;
    logic [DW-1:0]   a_y;
    logic [SW-1:0]   a_ch;
    logic            a_ovalid, a_oready;
    logic [CW-1:0]   a_cnt;

    logic [NB*DW-1:0] b_data;
    logic [NB-1:0]    b_valid, b_ready;
    logic             b_mode;
    logic [1:0]       b_sel;
    logic [DW-1:0]    b_y;
    logic [1:0]       b_ch;
    logic             b_ovalid, b_oready;
    logic [CWB-1:0]   b_cnt;

    rr_stream_mux #(.NUM_CH(N), .DATA_W(DW), .SEL_W(SW), .CNT_W(CW)) dut_a (
        .clk(clk), .rst_n(rst_n), .inp_data(a_data), .inp_valid(a_valid),
        .inp_ready(a_ready), .mode_rr(a_mode), .selec(a_sel), .out_y(a_y),
        .out_ch(a_ch), .out_valid(a_ovalid), .out_ready(a_oready), .beat_cnt(a_cnt)
    );

    rr_stream_mux #(.NUM_CH(NB), .DATA_W(DW), .SEL_W(2), .CNT_W(CWB)) dut_b (
        .clk(clk), .rst_n(rst_n), .inp_data(b_data), .inp_valid(b_valid),
        .inp_ready(b_ready), .mode_rr(b_mode), .selec(b_sel), .out_y(b_y),
        .out_ch(b_ch), .out_valid(b_ovalid), .out_ready(b_oready), .beat_cnt(b_cnt)
    );

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [DW-1:0] d;
        int            ch;
    } beat_t;
    beat_t sb[$];
    beat_t mon_e;

    // Reference model: a one-slot buffer plus the index of the last
    // round-robin winner, advanced with plain arithmetic.
    bit            m_occ;
    int            m_last;
    int            m_cnt;
    logic [DW-1:0] m_y;
    int            m_ch;

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic cycle(input bit rst, input bit mode, input logic [1:0] sel,
                         input logic [3:0] vld, input logic [63:0] data, input bit ordy);
        int       g;
        bit       load;
        logic [3:0] exp_rdy;
        @(negedge clk);
        rst_n    = rst;
        a_mode   = mode;
        a_sel    = sel;
        a_valid  = vld;
        a_data   = data;
        a_oready = ordy;
        #1;
        chk("out_valid", a_ovalid, m_occ);
        chk("out_y", a_y, m_y);
        chk("out_ch", a_ch, m_ch);
        chk("beat_cnt", a_cnt, m_cnt % 65536);
        if (!rst) begin
            chk("inp_ready_in_reset", a_ready, 0);
            m_occ  = 0;
            m_y    = '0;
            m_ch   = 0;
            m_cnt  = 0;
            m_last = N - 1;
            sb.delete();
            return;
        end
        g = -1;
        if (!mode) begin
            if (int'(sel) < N && vld[sel]) g = int'(sel);
        end else begin
            for (int i = 1; i <= N; i++) begin
                if (g < 0 && vld[(m_last + i) % N]) g = (m_last + i) % N;
            end
        end
        load    = (!m_occ || ordy) && (g >= 0);
        exp_rdy = load ? 4'(1 << g) : 4'd0;
        chk("inp_ready", a_ready, exp_rdy);
        if (m_occ && ordy) m_cnt++;
        if (load) begin
            m_y   = data[g*DW +: DW];
            m_ch  = g;
            m_occ = 1;
            sb.push_back('{m_y, g});
            if (mode) m_last = g;
        end else if (m_occ && ordy) begin
            m_occ = 0;
        end
    endtask

    // Scoreboard monitor: pops one expected beat per output handshake.
    always @(negedge clk) begin
        #2;
        if (rst_n === 1'b1 && a_ovalid === 1'b1 && a_oready === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL sb_unexpected_beat: got %0h ch %0d expected none at %0t", a_y, a_ch, $time);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_data", a_y, mon_e.d);
                chk("sb_ch", a_ch, mon_e.ch);
            end
        end
    end

    task automatic cycb(input logic [1:0] sel, input logic [2:0] vld, input bit ordy,
                        input logic [2:0] exp_rdy, input bit exp_ov, input int exp_cnt);
        @(negedge clk);
        b_sel    = sel;
        b_valid  = vld;
        b_oready = ordy;
        #1;
        chk("b_inp_ready", b_ready, exp_rdy);
        chk("b_out_valid", b_ovalid, exp_ov);
        chk("b_beat_cnt", b_cnt, exp_cnt);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; a_mode = 1'b0; a_sel = '0; a_valid = '0; a_data = '0; a_oready = 1'b0;
        b_mode = 1'b0; b_sel = 2'd3; b_valid = '0; b_data = {16'h3333, 16'h2222, 16'hCAFE}; b_oready = 1'b0;
        m_occ = 0; m_last = N - 1; m_cnt = 0; m_y = '0; m_ch = 0;
        repeat (2) @(posedge clk);

        // reset then fixed select of channel 2
        repeat (2) cycle(1'b0, 1'b0, 2'd2, 4'hF, rnd64(), 1'b1);
        repeat (5) cycle(1'b1, 1'b0, 2'd2, 4'hF, {16'($urandom), 16'hBEEF, 32'($urandom)}, 1'b1);

        // round-robin, all channels valid
        repeat (8) cycle(1'b1, 1'b1, 2'd0, 4'hF, {16'h0003, 16'h0002, 16'h0001, 16'h0000}, 1'b1);

        // round-robin skip over idle channels
        repeat (8) cycle(1'b1, 1'b1, 2'd0, 4'b1010, rnd64(), 1'b1);

        // back-pressure with 16'h1234 held
        cycle(1'b1, 1'b0, 2'd0, 4'b0001, {48'(rnd64()), 16'h1234}, 1'b1);
        repeat (5) cycle(1'b1, 1'($urandom), 2'($urandom), 4'($urandom), rnd64(), 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 2'd0, 4'hF, rnd64(), 1'b1);

        // fixed select on an idle channel drains the slot
        repeat (3) cycle(1'b1, 1'b0, 2'd2, 4'b1011, rnd64(), 1'b1);

        // reset while a beat is held under back-pressure
        repeat (2) cycle(1'b1, 1'b0, 2'd1, 4'b0010, rnd64(), 1'b0);
        cycle(1'b0, 1'b0, 2'd1, 4'b0010, rnd64(), 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 2'd0, 4'hF, rnd64(), 1'b1);

        // randomized traffic
        repeat (400) cycle(($urandom % 60) != 0, 1'($urandom), 2'($urandom), 4'($urandom),
                           rnd64(), ($urandom % 4) != 0);

        // drain and confirm every issued beat was delivered
        repeat (3) cycle(1'b1, 1'b0, 2'd0, 4'd0, rnd64(), 1'b1);
        chk("sb_leftover", 64'(sb.size()), 0);

        // three-channel instance: out-of-range select never grants
        repeat (4) cycb(2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 0);
        // four-bit counter wraps after sixteen accepted beats
        for (int j = 0; j <= 17; j++) begin
            cycb(2'd0, 3'b111, 1'b1, 3'b001, j > 0, (j == 0) ? 0 : (j - 1) % 16);
        end
        chk("b_out_y", b_y, 16'hCAFE);
        chk("b_out_ch", b_ch, 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
